// File: rtl/riscv_dram_arbiter.sv
// Shared DRAM arbiter between the I-cache refill path and the D-cache refill/writeback path.
// A winning request is latched and its command is held on the DRAM port until mem_ready.
// The line is then returned to the winner, and that requester's ready pulses for one cycle.
// Optional build macro RISCV_DRAM_ARB_RR_EN: round-robin arbitration when both caches
// request in IDLE. Without it, the D-cache always beats the I-cache.
module riscv_dram_arbiter #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned S_ADDR     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rden,
  input  logic [S_ADDR-1:0]     i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_wren,
  input  logic                  d_rden,
  input  logic [S_ADDR-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  dram_wren,
  output logic                  dram_rden,
  output logic [S_ADDR-1:0]     dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ready,
  output logic                  busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            pick;
  logic                  d_req;
  logic                  cmd_wren_q, cmd_rden_q;
  logic [S_ADDR-1:0]     cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  assign d_req = d_wren | d_rden;

`ifdef RISCV_DRAM_ARB_RR_EN
  // 0: I-cache preferred on a tie, 1: D-cache preferred
  logic rr_q;

  // Arbitrate using the round-robin pointer on a tie
  always_comb begin
    pick = GNT_NONE;
    if (d_req && i_rden) begin
      pick = rr_q ? GNT_D : GNT_I;
    end else if (d_req) begin
      pick = GNT_D;
    end else if (i_rden) begin
      pick = GNT_I;
    end
  end

  // Pointer flips to the other requester after every completed grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (state_q == DONE) begin
      rr_q <= (grant_q == GNT_I);
    end
  end
`else
  // Fixed priority: D-cache beats I-cache
  always_comb begin
    pick = GNT_NONE;
    if (d_req) begin
      pick = GNT_D;
    end else if (i_rden) begin
      pick = GNT_I;
    end
  end
`endif

  // Next-state and grant selection
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = GRANT;
          grant_d = pick;
        end
      end
      GRANT:  state_d = ACCESS;
      ACCESS: if (dram_ready) state_d = DONE;
      DONE:   state_d = RECOVER;
      RECOVER: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Command capture in GRANT; a combined D write+read performs only the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wren_q  <= 1'b0;
      cmd_rden_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (state_q == GRANT) begin
      if (grant_q == GNT_D) begin
        cmd_wren_q  <= d_wren;
        cmd_rden_q  <= ~d_wren;
        cmd_addr_q  <= d_addr;
        cmd_wdata_q <= d_wdata;
      end else begin
        cmd_wren_q  <= 1'b0;
        cmd_rden_q  <= 1'b1;
        cmd_addr_q  <= i_addr;
      end
    end
  end

  // Return-line registers, loaded only by a read completing for that requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if ((state_q == ACCESS) && dram_ready && cmd_rden_q) begin
      if (grant_q == GNT_I) begin
        i_rdata_q <= dram_rdata;
      end else if (grant_q == GNT_D) begin
        d_rdata_q <= dram_rdata;
      end
    end
  end

  // Strobes are qualified by ACCESS so they drop in DONE and on async reset
  always_comb begin
    dram_wren  = (state_q == ACCESS) & cmd_wren_q;
    dram_rden  = (state_q == ACCESS) & cmd_rden_q;
    dram_addr  = cmd_addr_q;
    dram_wdata = cmd_wdata_q;
    i_ready    = (state_q == DONE) & (grant_q == GNT_I);
    d_ready    = (state_q == DONE) & (grant_q == GNT_D);
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_riscv_dram_arbiter.sv
// Directed bench for riscv_dram_arbiter with a 3-cycle DRAM model and a completion scoreboard.
`timescale 1ns/1ps
module tb_riscv_dram_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mdl_rst_n = 1'b0;
  logic          i_rden = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_wren = 1'b0;
  logic          d_rden = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          dram_wren, dram_rden;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] dram_rdata;
  logic          dram_ready;
  logic          busy;

  riscv_dram_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rden     (i_rden),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_wren     (d_wren),
    .d_rden     (d_rden),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .dram_wren  (dram_wren),
    .dram_rden  (dram_rden),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_ready (dram_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_init(input logic [AW-1:0] a);
    return {4{a, 22'h15A5A5}};
  endfunction

  // DRAM model: ready one cycle after the third command cycle; counter clears when idle
  logic [DW-1:0]   mem [1024];
  logic [1023:0]   wr_valid;
  logic [1:0]      cnt;
  always_ff @(posedge clk or negedge mdl_rst_n) begin
    if (!mdl_rst_n) begin
      cnt        <= '0;
      dram_ready <= 1'b0;
      dram_rdata <= '0;
      wr_valid   <= '0;
    end else begin
      dram_ready <= 1'b0;
      if (!(dram_wren || dram_rden) || dram_ready) begin
        cnt <= '0;
      end else if (cnt == 2'd2) begin
        cnt        <= '0;
        dram_ready <= 1'b1;
        if (dram_wren) begin
          mem[dram_addr]      <= dram_wdata;
          wr_valid[dram_addr] <= 1'b1;
        end else begin
          dram_rdata <= wr_valid[dram_addr] ? mem[dram_addr] : line_init(dram_addr);
        end
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t           sb [$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] i_pend = '0;
  logic [DW-1:0] d_pend = '0;
  logic          rr_pref_d = 1'b0;
  logic [7:0]    order = '0;
  int            n_done = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] ref_line(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return line_init(a);
  endfunction

  function automatic logic first_is_d();
`ifdef RISCV_DRAM_ARB_RR_EN
    return rr_pref_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_line(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected completion, in the order the arbiter should serve it
  task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    sb_t it;
    it.is_d  = is_d;
    it.wr    = wr;
    it.addr  = a;
    it.wdata = wd;
    if (wr) begin
      ref_mem[int'(a)] = wd;
      it.rdata = d_pend;
    end else begin
      it.rdata = ref_line(a);
      if (is_d) d_pend = it.rdata;
      else      i_pend = it.rdata;
    end
    sb.push_back(it);
  endtask

  // One clock, then check the DRAM command and any ready pulse against the scoreboard
  task automatic tick();
    sb_t it;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk_int("cmd_idle", int'(dram_wren | dram_rden), 0);
    end else if (dram_wren || dram_rden) begin
      chk_int("cmd_one_hot", int'(dram_wren & dram_rden), 0);
      chk_int("cmd_addr", int'(dram_addr), int'(sb[0].addr));
      chk_int("cmd_wren", int'(dram_wren), int'(sb[0].wr));
      if (sb[0].wr) chk_line("cmd_wdata", dram_wdata, sb[0].wdata);
    end
    if (i_ready || d_ready) begin
      chk_int("ready_excl", int'(i_ready & d_ready), 0);
      if (sb.size() == 0) begin
        chk_int("ready_spurious", int'({i_ready, d_ready}), 0);
      end else begin
        it = sb.pop_front();
        chk_int("ready_who", int'(d_ready), int'(it.is_d));
        if (it.is_d) chk_line("d_rdata", d_rdata, it.rdata);
        else         chk_line("i_rdata", i_rdata, it.rdata);
        rr_pref_d = !it.is_d;
        order     = {order[6:0], it.is_d};
        n_done++;
      end
      if (i_ready) i_rden = 1'b0;
      if (d_ready) begin
        d_wren = 1'b0;
        d_rden = 1'b0;
      end
    end
  endtask

  // Run until the scoreboard drains, then let DONE/RECOVER return to IDLE
  task automatic drain(input string tag);
    for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
    chk_int(tag, sb.size(), 0);
    tick();
    tick();
    chk_int("idle_after", int'(busy), 0);
  endtask

  task automatic dual_round(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    logic fd;
    int   n0;
    fd = first_is_d();
    n0 = n_done;
    if (fd) begin
      push(1'b1, 1'b0, da, '0);
      push(1'b0, 1'b0, ia, '0);
    end else begin
      push(1'b0, 1'b0, ia, '0);
      push(1'b1, 1'b0, da, '0);
    end
    i_addr = ia;
    d_addr = da;
    i_rden = 1'b1;
    d_rden = 1'b1;
    drain("dual_drain");
    chk_int("dual_count", n_done - n0, 2);
    chk_int("dual_order", int'(order[1:0]), fd ? 2 : 1);
  endtask

  initial begin
    int n0;

    // Reset state
    #12;
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_cmd", int'({dram_wren, dram_rden}), 0);
    chk_int("rst_ready", int'({i_ready, d_ready}), 0);
    chk_int("rst_addr", int'(dram_addr), 0);
    chk_line("rst_i_rdata", i_rdata, '0);
    chk_line("rst_d_rdata", d_rdata, '0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mdl_rst_n = 1'b1;
    tick();

    // I-cache read of 005, with command latency
    n0 = n_done;
    push(1'b0, 1'b0, 10'h005, '0);
    i_addr = 10'h005;
    i_rden = 1'b1;
    tick();
    chk_int("lat_grant_busy", int'(busy), 1);
    chk_int("lat_grant_rden", int'(dram_rden), 0);
    tick();
    chk_int("lat_access_rden", int'(dram_rden), 1);
    drain("iread_drain");
    chk_int("iread_count", n_done - n0, 1);

    // D-cache writeback of A5.. to 3FF, then I-cache read back
    push(1'b1, 1'b1, 10'h3FF, {16{8'hA5}});
    d_addr  = 10'h3FF;
    d_wdata = {16{8'hA5}};
    d_wren  = 1'b1;
    drain("dwr_drain");
    push(1'b0, 1'b0, 10'h3FF, '0);
    i_addr = 10'h3FF;
    i_rden = 1'b1;
    drain("rdback_drain");
    chk_line("rdback_line", i_rdata, {16{8'hA5}});

    // Simultaneous requests: fixed priority or round-robin, per build
    dual_round(10'h020, 10'h030);
    for (int r = 0; r < 4; r++) dual_round(AW'(10'h100 + r), AW'(10'h200 + r));

    // Combined D write+read: write only, d_rdata unchanged, then the re-issued read
    push(1'b1, 1'b1, 10'h010, {4{32'h1357_9BDF}});
    d_addr  = 10'h010;
    d_wdata = {4{32'h1357_9BDF}};
    d_wren  = 1'b1;
    d_rden  = 1'b1;
    drain("wrrd_drain");
    chk_line("wrrd_d_rdata_kept", d_rdata, d_pend);
    push(1'b1, 1'b0, 10'h010, '0);
    d_rden = 1'b1;
    drain("wrrd_reread");
    chk_line("wrrd_reread_line", d_rdata, {4{32'h1357_9BDF}});

    // Reset pulled during ACCESS
    push(1'b0, 1'b0, 10'h040, '0);
    i_addr = 10'h040;
    i_rden = 1'b1;
    tick();
    tick();
    chk_int("mid_access_rden", int'(dram_rden), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("mid_rst_cmd", int'({dram_wren, dram_rden}), 0);
    chk_int("mid_rst_busy", int'(busy), 0);
    chk_int("mid_rst_ready", int'({i_ready, d_ready}), 0);
    sb.delete();
    i_rden    = 1'b0;
    i_pend    = '0;
    d_pend    = '0;
    rr_pref_d = 1'b0;
    n0        = n_done;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_int("post_rst_no_ready", n_done - n0, 0);
    chk_line("post_rst_i_rdata", i_rdata, '0);
    push(1'b1, 1'b0, 10'h055, '0);
    d_addr = 10'h055;
    d_rden = 1'b1;
    drain("post_rst_drain");
    chk_int("post_rst_count", n_done - n0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dram_arbiter.md
Name: riscv_dram_arbiter

Overview:
- Arbitrates the single shared DRAM model between the instruction-cache refill path and the data-cache refill/writeback path.
- Captures the winning request and holds DRAM wren/rden/addr/data stable until the DRAM reports mem_ready.
- Returns the DRAM line to the winner and pulses that requester's ready.
- Sits between both cache controllers and the DRAM model.

Parameters:
- DATA_WIDTH, 128, cache line / DRAM word width in bits.
- S_ADDR, 10, line address width (DRAM byte address minus line offset bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_rden  input  1  I-cache line read request, level, held until i_ready.
- i_addr  input  S_ADDR  I-cache line address.
- i_rdata  output  DATA_WIDTH  line returned to I-cache.
- i_ready  output  1  one-cycle pulse: I-cache request complete.
- d_wren  input  1  D-cache writeback request, level, held until d_ready.
- d_rden  input  1  D-cache line read request, level, held until d_ready.
- d_addr  input  S_ADDR  D-cache line address.
- d_wdata  input  DATA_WIDTH  D-cache writeback line.
- d_rdata  output  DATA_WIDTH  line returned to D-cache.
- d_ready  output  1  one-cycle pulse: D-cache request complete.
- dram_wren  output  1  to DRAM wren.
- dram_rden  output  1  to DRAM rden.
- dram_addr  output  S_ADDR  to DRAM addr.
- dram_wdata  output  DATA_WIDTH  to DRAM data_in.
- dram_rdata  input  DATA_WIDTH  from DRAM data_out.
- dram_ready  input  1  from DRAM mem_ready.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, grant register=NONE, rr pointer=I.
- States:
  - IDLE: no DRAM command. Any request → GRANT next cycle; grant winner is latched.
  - GRANT: copy winner's addr/wdata/op into command registers.
  - ACCESS: drive dram_* from command registers, constant, until dram_ready=1.
  - DONE: one cycle. dram_wren/dram_rden=0 so the DRAM counter clears; winner's ready=1.
  - RECOVER: one cycle. Requests are ignored so the winner can drop its request. Then return to IDLE.
- Latency: request seen in IDLE at cycle N → dram_rden/dram_wren high from N+2. Ready pulses on the cycle after dram_ready is sampled high.
- Winner's rdata: registered from dram_rdata on the dram_ready cycle; holds until that requester's next completion. Writebacks leave d_rdata unchanged.
- d_wren and d_rden both high: write performed first. d_rden is ignored for that grant; the D-cache re-requests the read after d_ready.
- Fixed priority (macro absent): D-cache beats I-cache.
- Requests changing while not in IDLE have no effect. Addr/data are sampled only in GRANT.
- dram_ready while not in ACCESS: ignored.
- Reset mid-ACCESS: DRAM command drops immediately, no ready pulse. The requester must reissue.
- Exactly one of dram_wren/dram_rden is high, and only in ACCESS.

Optional Feature:
- Macro: RISCV_DRAM_ARB_RR_EN.
- Defined: round-robin between I and D when both request in IDLE. The rr pointer names the preferred requester and flips to the other after each completed grant.
- Undefined: fixed D-over-I priority, no rr pointer logic.

Test Plan:
- Reset then i_rden=1, i_addr=10'h005; DRAM model with 3-cycle ready → dram_rden high with dram_addr=005 until ready. i_ready pulses once; i_rdata = DRAM line at 005. d_ready stays 0.
- d_wren=1, d_addr=10'h3FF, d_wdata=128'hA5…A5 → dram_wren held, dram_wdata=A5…A5. d_ready pulses. A following i_rden read of 3FF returns A5…A5.
- i_rden and d_rden asserted same cycle, macro undefined → D served first, then I. Exactly two ready pulses, D before I.
- Same as the previous case with RISCV_DRAM_ARB_RR_EN defined, four back-to-back dual-request rounds → grants alternate I,D,I,D.
- d_wren and d_rden both high for d_addr=10'h010 → only dram_wren issued. d_rdata unchanged after d_ready.
- rst_n pulled low during ACCESS → dram_wren/dram_rden/busy go to 0 asynchronously, no ready pulse. After release, state is IDLE and a new request completes normally.
